// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ALU issue register with operand select, EX/MEM forwarding, 2-entry skid buffer and flush (in: decode op + ex/mem bypass, out: valid/ready op a,b,aluc,rd,wreg)
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [DW-1:0] in_qa,
  input  logic [DW-1:0] in_qb,
  input  logic [DW-1:0] in_imm,
  input  logic [4:0]    in_sa,
  input  logic          in_aluimm,
  input  logic          in_shift,
  input  logic [3:0]    in_aluc,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wreg,
  input  logic          ex_wreg,
  input  logic [RW-1:0] ex_rd,
  input  logic [DW-1:0] ex_r,
  input  logic          mem_wreg,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [3:0]    out_aluc,
  output logic [RW-1:0] out_rd,
  output logic          out_wreg
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t r_state, w_next;
  logic w_acc, w_load_out, w_load_sk, w_from_sk;
  logic [DW-1:0] w_fa, w_fb, w_a, w_b;
  logic [DW-1:0] r_a, r_b, r_sk_a, r_sk_b;
  logic [3:0] r_aluc, r_sk_aluc;
  logic [RW-1:0] r_rd, r_sk_rd;
  logic r_wreg, r_sk_wreg;
  assign w_fa = (in_rs != '0 && ex_wreg && ex_rd == in_rs) ? ex_r :
                (in_rs != '0 && mem_wreg && mem_rd == in_rs) ? mem_r : in_qa;
  assign w_fb = (in_rt != '0 && ex_wreg && ex_rd == in_rt) ? ex_r :
                (in_rt != '0 && mem_wreg && mem_rd == in_rt) ? mem_r : in_qb;
  assign w_a = in_shift ? {{(DW-5){1'b0}}, in_sa} : w_fa;
  assign w_b = in_aluimm ? in_imm : w_fb;
  assign in_ready  = r_state != TWO;
  assign out_valid = r_state != EMPTY;
  assign w_acc      = in_valid & in_ready;
  assign w_load_out = w_acc & (r_state == EMPTY | out_ready);
  assign w_load_sk  = w_acc & (r_state == ONE) & ~out_ready;
  assign w_from_sk  = (r_state == TWO) & out_ready;
  always_comb begin
    w_next = flush ? EMPTY :
             r_state == EMPTY ? (w_acc ? ONE : EMPTY) :
             r_state == ONE   ? (w_acc ? (out_ready ? ONE : TWO) : (out_ready ? EMPTY : ONE)) :
                                (out_ready ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_aluc <= '0; r_rd <= '0; r_wreg <= 1'b0;
      r_sk_a <= '0; r_sk_b <= '0; r_sk_aluc <= '0; r_sk_rd <= '0; r_sk_wreg <= 1'b0;
    end else begin
      if (w_load_out) begin
        r_a <= w_a; r_b <= w_b; r_aluc <= in_aluc; r_rd <= in_rd; r_wreg <= in_wreg;
      end else if (w_from_sk) begin
        r_a <= r_sk_a; r_b <= r_sk_b; r_aluc <= r_sk_aluc; r_rd <= r_sk_rd; r_wreg <= r_sk_wreg;
      end
      if (w_load_sk) begin
        r_sk_a <= w_a; r_sk_b <= w_b; r_sk_aluc <= in_aluc; r_sk_rd <= in_rd; r_sk_wreg <= in_wreg;
      end
    end
  end
  assign out_a    = r_a;
  assign out_b    = r_b;
  assign out_aluc = r_aluc;
  assign out_rd   = r_rd;
  assign out_wreg = r_wreg;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage with directed vectors
module tb_alu_issue_stage;
  logic clk = 1'b0, rst, flush, in_valid, in_ready;
  logic [4:0] in_rs, in_rt, in_sa, in_rd, ex_rd, mem_rd, out_rd;
  logic [31:0] in_qa, in_qb, in_imm, ex_r, mem_r, out_a, out_b;
  logic in_aluimm, in_shift, in_wreg, ex_wreg, mem_wreg, out_valid, out_ready, out_wreg;
  logic [3:0] in_aluc, out_aluc;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [4:0]  rd;
    logic        wreg;
  } op_t;
  op_t exp_q[$];
  op_t prev, cur;
  logic stall = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_qa(in_qa), .in_qb(in_qb), .in_imm(in_imm),
    .in_sa(in_sa), .in_aluimm(in_aluimm), .in_shift(in_shift), .in_aluc(in_aluc),
    .in_rd(in_rd), .in_wreg(in_wreg), .ex_wreg(ex_wreg), .ex_rd(ex_rd), .ex_r(ex_r),
    .mem_wreg(mem_wreg), .mem_rd(mem_rd), .mem_r(mem_r), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_aluc(out_aluc),
    .out_rd(out_rd), .out_wreg(out_wreg)
  );
  assign cur = '{a: out_a, b: out_b, aluc: out_aluc, rd: out_rd, wreg: out_wreg};
  always @(negedge clk) begin
    if (!rst) begin
      if (stall) begin
        checks++;
        if (!out_valid || cur != prev) begin
          errors++;
          $display("FAIL stall_hold got v=%b %h want v=1 %h", out_valid, cur, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_op got a=%h b=%h aluc=%h rd=%0d want none", out_a, out_b, out_aluc, out_rd);
        end else begin
          op_t e;
          e = exp_q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL op got a=%h b=%h aluc=%h rd=%0d w=%b want a=%h b=%h aluc=%h rd=%0d w=%b",
                     out_a, out_b, out_aluc, out_rd, out_wreg, e.a, e.b, e.aluc, e.rd, e.wreg);
          end
        end
      end
      stall = out_valid && !out_ready && !flush;
      prev = cur;
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  task automatic set_op(input logic [4:0] rs, input logic [31:0] qa, input logic [4:0] rt,
                        input logic [31:0] qb, input logic [31:0] imm, input logic [4:0] sa,
                        input logic aluimm, input logic shift, input logic [3:0] aluc,
                        input logic [4:0] rd, input logic wreg);
    in_rs = rs; in_qa = qa; in_rt = rt; in_qb = qb; in_imm = imm; in_sa = sa;
    in_aluimm = aluimm; in_shift = shift; in_aluc = aluc; in_rd = rd; in_wreg = wreg;
    in_valid = 1'b1;
  endtask
  task automatic issue(input logic [4:0] rs, input logic [31:0] qa, input logic [4:0] rt,
                       input logic [31:0] qb, input logic [31:0] imm, input logic [4:0] sa,
                       input logic aluimm, input logic shift, input logic [3:0] aluc,
                       input logic [4:0] rd, input logic wreg,
                       input logic [31:0] ea, input logic [31:0] eb);
    int n = 0;
    op_t e;
    set_op(rs, qa, rt, qb, imm, sa, aluimm, shift, aluc, rd, wreg);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout got in_ready=0 want 1");
    end else begin
      @(posedge clk);
      e = '{a: ea, b: eb, aluc: aluc, rd: rd, wreg: wreg};
      exp_q.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask
  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    ex_wreg = 1'b0; ex_rd = '0; ex_r = '0; mem_wreg = 1'b0; mem_rd = '0; mem_r = '0;
    set_op(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd0, 1'b0, 1'b0, 4'h0, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_a", out_a, 32'h0);
    chk("rst_out_b", out_b, 32'h0);
    chk("rst_out_aluc_rd_wreg", {22'b0, out_aluc, out_rd, out_wreg}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    issue(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd0, 1'b0, 1'b0, 4'h0, 5'd3, 1'b1, 32'h1, 32'h2);
    chk("pass_latency_valid", {31'b0, out_valid}, 32'h1);
    chk("alu_sum", out_a + out_b, 32'h3);
    ex_wreg = 1'b1; ex_rd = 5'd5; ex_r = 32'hCCCCCCCC;
    mem_wreg = 1'b1; mem_rd = 5'd5; mem_r = 32'h1;
    issue(5'd5, 32'h11, 5'd5, 32'h22, 32'h0, 5'd0, 1'b0, 1'b0, 4'h1, 5'd4, 1'b1, 32'hCCCCCCCC, 32'hCCCCCCCC);
    ex_wreg = 1'b0;
    issue(5'd5, 32'h11, 5'd5, 32'h22, 32'h0, 5'd0, 1'b0, 1'b0, 4'h1, 5'd4, 1'b0, 32'h1, 32'h1);
    ex_wreg = 1'b1; ex_rd = 5'd0; mem_rd = 5'd0;
    issue(5'd0, 32'h1234, 5'd0, 32'h5678, 32'h0, 5'd0, 1'b0, 1'b0, 4'h2, 5'd6, 1'b1, 32'h1234, 32'h5678);
    ex_wreg = 1'b0; mem_wreg = 1'b0;
    issue(5'd0, 32'h0, 5'd3, 32'hFFFFFFFF, 32'h0, 5'h0F, 1'b0, 1'b1, 4'h3, 5'd7, 1'b1, 32'h0000000F, 32'hFFFFFFFF);
    issue(5'd0, 32'h0, 5'd3, 32'hFFFFFFFF, 32'hFF005555, 5'h0F, 1'b1, 1'b1, 4'h3, 5'd7, 1'b1, 32'h0000000F, 32'hFF005555);
    drain();
    out_ready = 1'b0;
    ex_wreg = 1'b1; ex_rd = 5'd5; ex_r = 32'hCCCCCCCC;
    issue(5'd5, 32'h11, 5'd6, 32'h22, 32'h0, 5'd0, 1'b0, 1'b0, 4'h2, 5'd7, 1'b1, 32'hCCCCCCCC, 32'h22);
    ex_r = 32'hDDDDDDDD;
    issue(5'd6, 32'h33, 5'd5, 32'h44, 32'h0, 5'd0, 1'b0, 1'b0, 4'h4, 5'd8, 1'b0, 32'h33, 32'hDDDDDDDD);
    ex_r = 32'hEEEEEEEE;
    @(negedge clk);
    chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
    chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    fork
      issue(5'd0, 32'h55, 5'd5, 32'h66, 32'h0, 5'd0, 1'b0, 1'b0, 4'h5, 5'd9, 1'b1, 32'h55, 32'hEEEEEEEE);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    ex_wreg = 1'b0;
    out_ready = 1'b0;
    issue(5'd1, 32'hA1, 5'd2, 32'hA2, 32'h0, 5'd0, 1'b0, 1'b0, 4'h6, 5'd10, 1'b1, 32'hA1, 32'hA2);
    issue(5'd1, 32'hB1, 5'd2, 32'hB2, 32'h0, 5'd0, 1'b0, 1'b0, 4'h7, 5'd11, 1'b1, 32'hB1, 32'hB2);
    flush = 1'b1;
    set_op(5'd1, 32'hC1, 5'd2, 32'hC2, 32'h0, 5'd0, 1'b0, 1'b0, 4'h8, 5'd12, 1'b1);
    @(posedge clk);
    exp_q.delete();
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(5'd3, 32'hD1, 5'd4, 32'hD2, 32'h0, 5'd0, 1'b0, 1'b0, 4'h9, 5'd13, 1'b1, 32'hD1, 32'hD2);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
